// File: rtl/detector_stream_ctrl_pkg.sv
// rtl/detector_stream_ctrl_pkg.sv - sequencer state encoding and default widths
package stream_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_DIV_W  = 24;
   localparam int DEF_CNT_W  = 5;

endpackage

// File: rtl/detector_stream_ctrl_if.sv
// rtl/detector_stream_ctrl_if.sv - control/detector bundle; STREAM_STEP_EN adds the step strobe
interface detector_stream_ctrl_if
   import stream_ctrl_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int DIV_W  = DEF_DIV_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic              start;
   logic              abort;
   logic [WORD_W-1:0] word;
   logic [DIV_W-1:0]  div;
   logic              det_out;
`ifdef STREAM_STEP_EN
   logic              step;
`endif
   logic              det_clr;
   logic              det_step;
   logic              det_in;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  hits;
   logic [4:0]        bit_idx;

   modport master (
`ifdef STREAM_STEP_EN
      output step,
`endif
      output start, abort, word, div, det_out,
      input  det_clr, det_step, det_in, busy, done, hits, bit_idx
   );

   modport slave (
`ifdef STREAM_STEP_EN
      input  step,
`endif
      input  start, abort, word, div, det_out,
      output det_clr, det_step, det_in, busy, done, hits, bit_idx
   );

endinterface

// File: rtl/detector_stream_ctrl_tick_gen.sv
// rtl/detector_stream_ctrl_tick_gen.sv - loadable down-counter, tick while count is zero
module tick_gen #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_en,
   output logic         o_tick
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/detector_stream_ctrl.sv
// rtl/detector_stream_ctrl.sv - streams a latched word MSB-first into the pattern detector and counts hits
// STREAM_STEP_EN: replaces the div prescaler with an external step strobe
module detector_stream_ctrl
   import stream_ctrl_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int DIV_W  = DEF_DIV_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic                   clk,
   input logic                   rst,
   detector_stream_ctrl_if.slave bus
);
   localparam logic [4:0] LAST_IDX = 5'(WORD_W);

   state_t            r_state;
   state_t            w_next;
   logic [WORD_W-1:0] r_shreg;
   logic [CNT_W-1:0]  r_hits;
   logic [4:0]        r_bit_idx;
   logic              w_accept;
   logic              w_tick;
   logic              w_step;

   assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start && !bus.abort;

`ifdef STREAM_STEP_EN
   assign w_tick = bus.step;
`else
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_reload;
   logic             w_load;

   // Reload with div_eff-1 so a RUN phase lasts div_eff cycles; div=0 behaves as 1
   assign w_reload = (r_div == '0) ? '0 : r_div - DIV_W'(1);
   assign w_load   = (r_state == LOAD) || ((r_state == SAMPLE) && (r_bit_idx != LAST_IDX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div <= '0;
      end else if (w_accept) begin
         r_div <= bus.div;
      end
   end

   tick_gen #(.W(DIV_W)) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_value (w_reload),
      .i_en    (r_state == RUN),
      .o_tick  (w_tick)
   );
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_step = 1'b0;
      case (r_state)
         IDLE, DONE: if (w_accept) w_next = LOAD;
         LOAD:       w_next = bus.abort ? IDLE : RUN;
         RUN: begin
            if (bus.abort) begin
               w_next = IDLE;
            end else if (w_tick) begin
               w_step = 1'b1;
               w_next = SAMPLE;
            end
         end
         SAMPLE: begin
            if (bus.abort)                    w_next = IDLE;
            else if (r_bit_idx == LAST_IDX)   w_next = DONE;
            else                              w_next = RUN;
         end
         default: w_next = IDLE;
      endcase
   end

   // Detector output is Moore, so the bit stepped last cycle is judged during SAMPLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shreg   <= '0;
         r_hits    <= '0;
         r_bit_idx <= '0;
      end else if (w_accept) begin
         r_shreg   <= bus.word;
         r_hits    <= '0;
         r_bit_idx <= '0;
      end else if (w_step) begin
         r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
         r_bit_idx <= r_bit_idx + 5'd1;
      end else if ((r_state == SAMPLE) && !bus.abort && bus.det_out && (r_hits != '1)) begin
         r_hits    <= r_hits + CNT_W'(1);
      end
   end

   assign bus.det_clr  = (r_state == LOAD);
   assign bus.det_step = w_step;
   assign bus.det_in   = w_step & r_shreg[WORD_W-1];
   assign bus.busy     = (r_state == LOAD) || (r_state == RUN) || (r_state == SAMPLE);
   assign bus.done     = (r_state == DONE);
   assign bus.hits     = r_hits;
   assign bus.bit_idx  = r_bit_idx;

endmodule

// File: tb/tb_detector_stream_ctrl.sv
// tb/tb_detector_stream_ctrl.sv - directed bench with run-of-four detector model; STREAM_STEP_EN selects step-mode test
module tb_detector_stream_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   npass = 0;
   int   ntot  = 0;

   always #5 clk = ~clk;

   detector_stream_ctrl_if #(.WORD_W(16), .DIV_W(24), .CNT_W(5)) if0 ();
   detector_stream_ctrl_if #(.WORD_W(16), .DIV_W(24), .CNT_W(3)) if1 ();

   detector_stream_ctrl #(.WORD_W(16), .DIV_W(24), .CNT_W(5)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   detector_stream_ctrl #(.WORD_W(16), .DIV_W(24), .CNT_W(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   assign if1.start = if0.start;
   assign if1.abort = if0.abort;
   assign if1.word  = if0.word;
   assign if1.div   = if0.div;
`ifdef STREAM_STEP_EN
   assign if1.step  = if0.step;
`endif

   // Detector model: output 1 once the last four stepped bits are all equal
   logic [2:0] m0_run, m1_run;
   logic       m0_last, m1_last;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_run <= 3'd0; m0_last <= 1'b0;
      end else if (if0.det_clr) begin
         m0_run <= 3'd0;
      end else if (if0.det_step) begin
         if (m0_run != 3'd0 && if0.det_in == m0_last) m0_run <= (m0_run == 3'd4) ? 3'd4 : m0_run + 3'd1;
         else m0_run <= 3'd1;
         m0_last <= if0.det_in;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m1_run <= 3'd0; m1_last <= 1'b0;
      end else if (if1.det_clr) begin
         m1_run <= 3'd0;
      end else if (if1.det_step) begin
         if (m1_run != 3'd0 && if1.det_in == m1_last) m1_run <= (m1_run == 3'd4) ? 3'd4 : m1_run + 3'd1;
         else m1_run <= 3'd1;
         m1_last <= if1.det_in;
      end
   end

   assign if0.det_out = (m0_run == 3'd4);
   assign if1.det_out = (m1_run == 3'd4);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run_check(input logic [15:0] w, input logic [23:0] d, input int exp_hits,
                            input int exp_lat, input bit poke);
      int         c = 0;
      int         de;
      int         last_step = 0;
      int         nsteps = 0;
      bit         spacing_ok = 1'b1;
      bit         overlap_ok = 1'b1;
      bit         prev_step = 1'b0;
      logic [15:0] got = '0;
      de = (d == 0) ? 1 : int'(d);
      @(negedge clk);
      if0.start = 1'b1; if0.word = w; if0.div = d;
      do begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            chk("load_det_clr", if0.det_clr, 1);
            chk("load_hits_zero", if0.hits, 0);
            chk("load_bit_idx_zero", if0.bit_idx, 0);
            if0.start = 1'b0;
         end
         if (poke && c == 10) begin
            if0.start = 1'b1; if0.word = ~w; if0.div = 24'd0;
         end
         if (poke && c == 11) if0.start = 1'b0;
         if (if0.det_step) begin
            got = {got[14:0], if0.det_in};
            if (prev_step || if0.det_clr || (c - last_step) != de + 1) spacing_ok = 1'b0;
            last_step = c;
            nsteps++;
         end
         if (if0.det_clr && c != 1) overlap_ok = 1'b0;
         prev_step = if0.det_step;
      end while (!if0.done && c < 2000);
      chk("run_done", if0.done, 1);
      chk("run_latency", c - 1, exp_lat);
      chk("run_steps", nsteps, 16);
      chk("run_bits_msb_first", got, w);
      chk("run_step_spacing", spacing_ok, 1);
      chk("run_no_extra_clr", overlap_ok, 1);
      chk("run_hits", if0.hits, exp_hits);
      chk("run_bit_idx", if0.bit_idx, 16);
      chk("run_busy_low", if0.busy, 0);
   endtask

   initial begin
      if0.start = 1'b0; if0.abort = 1'b0; if0.word = '0; if0.div = '0;
`ifdef STREAM_STEP_EN
      if0.step = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_det_clr", if0.det_clr, 0);
      chk("rst_det_step", if0.det_step, 0);
      chk("rst_det_in", if0.det_in, 0);
      chk("rst_busy", if0.busy, 0);
      chk("rst_done", if0.done, 0);
      chk("rst_hits", if0.hits, 0);
      chk("rst_bit_idx", if0.bit_idx, 0);
      rst = 1'b1;
      @(negedge clk);

`ifdef STREAM_STEP_EN
      if0.start = 1'b1; if0.word = 16'h0000; if0.div = 24'd5;
      @(negedge clk);
      if0.start = 1'b0;
      chk("step_load_clr", if0.det_clr, 1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk) if0.step = 1'b1;
         @(negedge clk) if0.step = 1'b0;
         repeat (2) @(negedge clk);
      end
      chk("step_done", if0.done, 1);
      chk("step_hits", if0.hits, 13);
      chk("step_bit_idx", if0.bit_idx, 16);
      chk("step_sat_hits", if1.hits, 7);
`else
      run_check(16'h0000, 24'd0, 13, 33, 1'b0);
      chk("sat_hits_cnt3", if1.hits, 7);

      @(negedge clk);
      if0.start = 1'b1; if0.abort = 1'b1;
      @(negedge clk);
      if0.start = 1'b0; if0.abort = 1'b0;
      chk("done_startabort_done", if0.done, 1);
      chk("done_startabort_clr", if0.det_clr, 0);

      run_check(16'h0F00, 24'd3, 7, 65, 1'b1);

      @(negedge clk);
      if0.start = 1'b1; if0.word = 16'h0F00; if0.div = 24'd1;
      @(negedge clk);
      if0.start = 1'b0;
      for (int k = 0; k < 200 && if0.bit_idx != 5'd5; k++) @(negedge clk);
      chk("abort_reach_idx5", if0.bit_idx, 5);
      @(negedge clk);
      chk("abort_pre_step", if0.det_step, 1);
      if0.abort = 1'b1;
      #1;
      chk("abort_blocks_step", if0.det_step, 0);
      @(negedge clk);
      if0.abort = 1'b0;
      chk("abort_busy", if0.busy, 0);
      chk("abort_done", if0.done, 0);
      chk("abort_bit_idx", if0.bit_idx, 5);
      chk("abort_hits_kept", if0.hits, 1);

      if0.start = 1'b1; if0.abort = 1'b1;
      @(negedge clk);
      if0.start = 1'b0; if0.abort = 1'b0;
      chk("idle_startabort_busy", if0.busy, 0);
      chk("idle_startabort_clr", if0.det_clr, 0);

      run_check(16'h0000, 24'd0, 13, 33, 1'b0);

      @(negedge clk);
      if0.start = 1'b1; if0.word = 16'hFFFF; if0.div = 24'd2;
      @(negedge clk);
      if0.start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_busy", if0.busy, 0);
      chk("mrst_done", if0.done, 0);
      chk("mrst_det_step", if0.det_step, 0);
      chk("mrst_det_clr", if0.det_clr, 0);
      chk("mrst_hits", if0.hits, 0);
      chk("mrst_bit_idx", if0.bit_idx, 0);
      @(negedge clk);
      rst = 1'b1;

      run_check(16'hA5F0, 24'd2, 3, 49, 1'b0);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
